// File: rtl/rdata_unpack_fifo4.sv
// Read-side unpacker: requests 64-bit words on credit, splits them into four lanes with per-lane FIFOs.
// Optional overflow checker enabled by defining UNPACK_OVF_CHK_EN.
module rdata_unpack_fifo4 #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_avail,
  output logic                    rd_req,
  input  logic [4*DATA_W-1:0]     rdata,
  output logic [4*DATA_W-1:0]     ch_data,
  output logic [3:0]              ch_valid,
  input  logic [3:0]              ch_ready,
  output logic [$clog2(DEPTH):0]  lvl_min
`ifdef UNPACK_OVF_CHK_EN
  ,
  output logic                    ovf_err,
  output logic [7:0]              ovf_cnt
`endif
);

  localparam int LANES = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  logic [DATA_W-1:0] r_mem [LANES][DEPTH];
  logic [PW-1:0]     r_wr  [LANES];
  logic [PW-1:0]     r_rd  [LANES];

  logic [PW-1:0]     w_occ [LANES];
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_pop;
  logic [PW-1:0]     w_max_occ;
  logic [PW-1:0]     w_min_occ;
  logic [PW-1:0]     w_free_min;
  logic [PW-1:0]     w_inflight;
  logic              w_acc;
  logic              w_cap;
  logic              w_push;

  // Valid/ready: lane k transfers on a rising clk edge where ch_valid[k] & ch_ready[k];
  // the upstream read is accepted where rd_req & rd_avail, and rd_req never looks at rd_avail.
  assign rd_req = ~reset & (w_free_min > w_inflight);
  assign w_acc  = rd_req & rd_avail;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign w_cap      = w_acc;
      assign w_inflight = '0;
    end else begin : g_latn
      logic [RD_LAT-1:0] r_vld;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_acc;
          for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
          end
        end
      end

      assign w_cap = r_vld[RD_LAT-1];

      always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
          w_inflight = w_inflight + PW'(r_vld[i]);
        end
      end
    end
  endgenerate

  always_comb begin
    w_max_occ = '0;
    w_min_occ = PW'(DEPTH);
    for (int k = 0; k < LANES; k++) begin
      w_occ[k]   = r_wr[k] - r_rd[k];
      w_empty[k] = (r_wr[k] == r_rd[k]);
      w_pop[k]   = ~w_empty[k] & ch_ready[k];
      if (w_occ[k] > w_max_occ) w_max_occ = w_occ[k];
      if (w_occ[k] < w_min_occ) w_min_occ = w_occ[k];
    end
  end

  // Credit is taken against the fullest lane so every lane can absorb each returning word.
  assign w_free_min = PW'(DEPTH) - w_max_occ;

`ifdef UNPACK_OVF_CHK_EN
  logic [LANES-1:0] w_full;
  logic             w_drop;
  logic             r_ovf_err;
  logic [7:0]       r_ovf_cnt;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_full[k] = (r_wr[k][AW] != r_rd[k][AW]) &&
                  (r_wr[k][AW-1:0] == r_rd[k][AW-1:0]);
    end
  end

  // A word that would overflow any lane is dropped everywhere so lanes stay aligned.
  assign w_drop = w_cap & (|(w_full & ~w_pop));
  assign w_push = w_cap & ~w_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_err <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf_err <= 1'b1;
      if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign ovf_cnt = r_ovf_cnt;
`else
  assign w_push = w_cap;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        r_wr[k] <= '0;
        r_rd[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_push) begin
          r_mem[k][r_wr[k][AW-1:0]] <= rdata[k*DATA_W +: DATA_W];
          r_wr[k]                   <= r_wr[k] + PW'(1);
        end
        if (w_pop[k]) r_rd[k] <= r_rd[k] + PW'(1);
      end
    end
  end

  always_comb begin
    ch_data  = '0;
    ch_valid = '0;
    lvl_min  = '0;
    if (!reset) begin
      ch_valid = ~w_empty;
      lvl_min  = w_min_occ;
      for (int k = 0; k < LANES; k++) begin
        ch_data[k*DATA_W +: DATA_W] = r_mem[k][r_rd[k][AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_rdata_unpack_fifo4.sv
// Bench for rdata_unpack_fifo4: randomized upstream/consumer traffic checked against a lane-occupancy model.
module tb_rdata_unpack_fifo4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int W      = 4 * DATA_W;

  logic          clk;
  logic          reset;
  logic          rd_avail;
  logic          rd_req;
  logic [W-1:0]  rdata;
  logic [W-1:0]  ch_data;
  logic [3:0]    ch_valid;
  logic [3:0]    ch_ready;
  logic [3:0]    lvl_min;
`ifdef UNPACK_OVF_CHK_EN
  logic          ovf_err;
  logic [7:0]    ovf_cnt;
`endif

  rdata_unpack_fifo4 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_avail (rd_avail),
    .rd_req   (rd_req),
    .rdata    (rdata),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .lvl_min  (lvl_min)
`ifdef UNPACK_OVF_CHK_EN
    ,
    .ovf_err  (ovf_err),
    .ovf_cnt  (ovf_cnt)
`endif
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           hd [4];
  int           occ [4];
  int           pend;
  int           n_acc;
  int           total;
  int           bad;
  logic         rd_pend;
  logic [W-1:0] next_word;
  logic [W-1:0] first_words [2];
  logic         chk_req;
  int           chk_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // monitor + reference model: lanes are queues of accepted words, credit from occupancy counts
  initial begin
    logic [3:0]   ev;
    logic [W-1:0] ew;
    logic [W-1:0] word;
    logic         acc;
    int           maxo;
    int           mino;
    int           popk;
    total = 0; bad = 0; n_acc = 0; pend = 0; rd_pend = 1'b0; next_word = '0;
    first_words[0] = 64'h0004_0003_0002_0001;
    first_words[1] = 64'h0008_0007_0006_0005;
    for (int k = 0; k < 4; k++) begin
      hd[k] = 0;
      occ[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_ch_valid", 64'(ch_valid), 64'd0);
        chk("rst_lvl_min", 64'(lvl_min), 64'd0);
        chk("rst_ch_data", ch_data, 64'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
          hd[k] = 0;
          occ[k] = 0;
        end
        pend = 0;
        rd_pend = 1'b0;
      end else begin
        maxo = 0;
        mino = DEPTH;
        for (int k = 0; k < 4; k++) begin
          if (occ[k] > maxo) maxo = occ[k];
          if (occ[k] < mino) mino = occ[k];
          ev[k] = (occ[k] > 0);
        end
        chk("rd_req", 64'(rd_req), 64'((DEPTH - maxo) > pend));
        chk("ch_valid", 64'(ch_valid), 64'(ev));
        chk("lvl_min", 64'(lvl_min), 64'(mino));
`ifdef UNPACK_OVF_CHK_EN
        chk("ovf_err", 64'(ovf_err), 64'd0);
        chk("ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        if (chk_req) chk("phase_accepts", 64'(n_acc), 64'(chk_exp));
        for (int k = 0; k < 4; k++) begin
          popk = 0;
          if (occ[k] > 0 && ch_ready[k]) begin
            popk = 1;
            if (hd[k] < exp_q.size()) begin
              ew = exp_q[hd[k]];
              chk($sformatf("lane%0d_data", k), 64'(ch_data[k*DATA_W +: DATA_W]),
                  64'(ew[k*DATA_W +: DATA_W]));
            end else begin
              chk($sformatf("lane%0d_underrun", k), 64'(hd[k]), 64'(exp_q.size()));
            end
            hd[k]++;
          end
          occ[k] = occ[k] + pend - popk;
        end
        acc = rd_req & rd_avail;
        pend = acc ? 1 : 0;
        rd_pend = acc;
        if (acc) begin
          if (n_acc < 2) word = first_words[n_acc];
          else word = {$urandom, $urandom};
          exp_q.push_back(word);
          next_word = word;
          n_acc++;
        end
      end
    end
  end

  // upstream RAM model: word for an accept appears one cycle later, garbage otherwise
  initial begin
    rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      rdata = rd_pend ? next_word : {$urandom, $urandom};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_check(input int base, input int delta);
    chk_exp = base + delta;
    chk_req = 1'b1;
    step(1);
    chk_req = 1'b0;
  endtask

  // driver
  initial begin
    int base;
    reset = 1'b1; rd_avail = 1'b0; ch_ready = 4'h0; chk_req = 1'b0; chk_exp = 0;
    step(3);
    reset = 1'b0;

    // two known words, consumers always ready
    base = n_acc;
    rd_avail = 1'b1; ch_ready = 4'hF;
    step(2);
    rd_avail = 1'b0;
    run_check(base, 2);
    step(6);

    // fill with consumers stalled: exactly DEPTH accepts
    base = n_acc;
    ch_ready = 4'h0; rd_avail = 1'b1;
    step(15);
    run_check(base, DEPTH);

    // lane3 drains 3 while lanes 0-2 stay full: no credit
    base = n_acc;
    ch_ready = 4'b1000;
    step(3);
    ch_ready = 4'h0;
    step(4);
    run_check(base, 0);

    // lanes 0-2 drain one each: exactly one new request
    base = n_acc;
    ch_ready = 4'b0111;
    step(1);
    ch_ready = 4'h0;
    step(6);
    run_check(base, 1);

    rd_avail = 1'b0; ch_ready = 4'hF;
    step(12);

    // rd_avail toggling
    base = n_acc;
    for (int i = 0; i < 8; i++) begin
      rd_avail = (i % 2 == 0);
      step(1);
    end
    rd_avail = 1'b0;
    run_check(base, 4);

    repeat (400) begin
      rd_avail = 1'($urandom_range(0, 1));
      ch_ready = 4'($urandom_range(0, 15));
      step(1);
    end

    // reset with one read in flight
    rd_avail = 1'b0; ch_ready = 4'hF;
    step(12);
    rd_avail = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    repeat (200) begin
      rd_avail = 1'($urandom_range(0, 1));
      ch_ready = 4'($urandom_range(0, 15));
      step(1);
    end
    rd_avail = 1'b0; ch_ready = 4'hF;
    step(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
